// File: rtl/lvds_rx_phase_align.sv
// lvds_rx_phase_align
// Phase-alignment controller for a 7:1 LVDS receive PLL. Resets the PLL, waits for
// lock, sweeps all 16 dynamic phases against the deserializer's training-pattern
// match flag, then parks psda at the centre of the widest circular passing eye.
// Optional in-service eye monitor: define LVDS_ALIGN_MON_EN to enable it.
module lvds_rx_phase_align #(
    parameter int unsigned RST_CYC    = 16,
    parameter int unsigned LOCK_TMO   = 65535,
    parameter int unsigned SETTLE_CYC = 64,
    parameter int unsigned SAMPLE_CYC = 256,
    parameter int unsigned MIN_EYE    = 3,
    parameter int unsigned MAX_RETRY  = 3,
    parameter logic [3:0]  DUTY_DEF   = 4'b1000,
    parameter logic [3:0]  FDLY_DEF   = 4'b0000,
    parameter int unsigned MON_ERR_TH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       pll_lock,
    input  logic       pat_valid,
    input  logic       pat_ok,
    output logic       pll_reset,
    output logic [3:0] psda,
    output logic [3:0] dutyda,
    output logic [3:0] fdly,
    output logic       busy,
    output logic       aligned,
    output logic       align_fail,
    output logic [3:0] eye_start,
    output logic [4:0] eye_width
);

    // General cycle counter must cover the longest timed interval (and 32 CENTER steps).
    localparam int unsigned CNT_MAX_A = (LOCK_TMO > RST_CYC) ? LOCK_TMO : RST_CYC;
    localparam int unsigned CNT_MAX_B = (CNT_MAX_A > SETTLE_CYC) ? CNT_MAX_A : SETTLE_CYC;
    localparam int unsigned CNT_MAX   = (CNT_MAX_B > 32) ? CNT_MAX_B : 32;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
    localparam int unsigned SMP_W     = $clog2(SAMPLE_CYC + 1);
    localparam int unsigned RTY_W     = $clog2(MAX_RETRY + 2);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PLL_RST,
        ST_WAIT_LOCK,
        ST_SETTLE,
        ST_SAMPLE,
        ST_CENTER,
        ST_DONE,
        ST_FAIL
    } state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [SMP_W-1:0]   smp_cnt, smp_nx;
    logic [SMP_W-1:0]   err_cnt, err_nx, err_sum;
    logic [15:0]        pass_map, pass_nx;
    logic [RTY_W-1:0]   retry_cnt, retry_nx, retry_inc;
    logic [4:0]         run, run_nx, best, best_nx, run_step, best_fin;
    logic [3:0]         best_end, best_end_nx, end_fin, start_fin, centre_fin;
    logic [3:0]         psda_nx, eye_start_nx;
    logic [4:0]         eye_width_nx;
    logic               best_upd, retry_go;
    logic               lock_meta, lock_s;

    assign dutyda = DUTY_DEF;
    assign fdly   = FDLY_DEF;

    // Two-flop synchroniser for the asynchronous PLL lock indication.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
        if (!rst_n) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
        end
    end

    // Next-state and next-register values for the whole controller.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_nx     = state;
        cnt_nx       = cnt;
        smp_nx       = smp_cnt;
        err_nx       = err_cnt;
        pass_nx      = pass_map;
        retry_nx     = retry_cnt;
        run_nx       = run;
        best_nx      = best;
        best_end_nx  = best_end;
        psda_nx      = psda;
        eye_start_nx = eye_start;
        eye_width_nx = eye_width;
        retry_go     = 1'b0;
        retry_inc    = retry_cnt + 1'b1;

        // Saturating error accumulation for the current sample.
        err_sum = (!pat_ok && err_cnt != '1) ? err_cnt + 1'b1 : err_cnt;

        // Circular run-length scan step at position cnt mod 16.
        run_step   = pass_map[cnt[3:0]] ? ((run == 5'd16) ? run : run + 5'd1) : 5'd0;
        best_upd   = run_step > best;
        best_fin   = best_upd ? run_step : best;
        end_fin    = best_upd ? cnt[3:0] : best_end;
        start_fin  = end_fin - best_fin[3:0] + 4'd1;
        centre_fin = start_fin + best_fin[4:1];

        unique case (state)
            ST_IDLE, ST_FAIL: begin
                if (start) begin
                    state_nx = ST_PLL_RST;
                    retry_nx = '0;
                    pass_nx  = '0;
                end
            end
            ST_PLL_RST: begin
                cnt_nx = cnt + 1'b1;
                if (cnt == CNT_W'(RST_CYC - 1)) state_nx = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                cnt_nx = cnt + 1'b1;
                if (lock_s) state_nx = ST_SETTLE;
                else if (cnt == CNT_W'(LOCK_TMO - 1)) retry_go = 1'b1;
            end
            ST_SETTLE: begin
                cnt_nx = cnt + 1'b1;
                if (!lock_s) retry_go = 1'b1;
                else if (cnt == CNT_W'(SETTLE_CYC - 1)) state_nx = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (!lock_s) begin
                    retry_go = 1'b1;
                end else if (pat_valid) begin
                    smp_nx = smp_cnt + 1'b1;
                    err_nx = err_sum;
                    if (smp_cnt == SMP_W'(SAMPLE_CYC - 1)) begin
                        pass_nx[psda] = (err_sum == '0);
                        if (psda == 4'd15) begin
                            state_nx = ST_CENTER;
                        end else begin
                            psda_nx  = psda + 4'd1;
                            state_nx = ST_SETTLE;
                        end
                    end
                end
            end
            ST_CENTER: begin
                if (!lock_s) begin
                    retry_go = 1'b1;
                end else begin
                    cnt_nx      = cnt + 1'b1;
                    run_nx      = run_step;
                    best_nx     = best_fin;
                    best_end_nx = end_fin;
                    if (cnt[4:0] == 5'd31) begin
                        eye_start_nx = start_fin;
                        eye_width_nx = best_fin;
                        if (best_fin >= 5'(MIN_EYE)) begin
                            psda_nx  = centre_fin;
                            state_nx = ST_DONE;
                        end else begin
                            state_nx = ST_FAIL;
                        end
                    end
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_nx = ST_PLL_RST;
                    retry_nx = '0;
                    pass_nx  = '0;
                end else if (!lock_s) begin
                    retry_go = 1'b1;
`ifdef LVDS_ALIGN_MON_EN
                end else if (pat_valid) begin
                    // Windowed in-service error count; a bad window forces a fresh alignment.
                    smp_nx = smp_cnt + 1'b1;
                    err_nx = err_sum;
                    if (smp_cnt == SMP_W'(SAMPLE_CYC - 1)) begin
                        if (err_sum >= SMP_W'(MON_ERR_TH)) begin
                            state_nx = ST_PLL_RST;
                            retry_nx = '0;
                            pass_nx  = '0;
                        end else begin
                            smp_nx = '0;
                            err_nx = '0;
                        end
                    end
`endif
                end
            end
            default: state_nx = ST_IDLE;
        endcase

        if (retry_go) begin
            retry_nx = retry_inc;
            state_nx = (retry_inc > RTY_W'(MAX_RETRY)) ? ST_FAIL : ST_PLL_RST;
        end

        // Every state entry restarts the interval counter and the sample window.
        if (state_nx != state) cnt_nx = '0;
        if (state_nx != state || !(state == ST_SAMPLE || state == ST_DONE)) begin
            smp_nx = '0;
            err_nx = '0;
        end
        if (state != ST_CENTER) begin
            run_nx      = '0;
            best_nx     = '0;
            best_end_nx = '0;
        end
        // PLL reset, lock wait and failure all park the phase at 0.
        if (state_nx == ST_PLL_RST || state_nx == ST_FAIL) psda_nx = '0;
    end

    // State register plus all registered outputs and datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            smp_cnt    <= '0;
            err_cnt    <= '0;
            // NOTE: the pass map is a small flop vector, so it is reset with everything else.
            pass_map   <= '0;
            retry_cnt  <= '0;
            run        <= '0;
            best       <= '0;
            best_end   <= '0;
            psda       <= '0;
            eye_start  <= '0;
            eye_width  <= '0;
            pll_reset  <= 1'b0;
            busy       <= 1'b0;
            aligned    <= 1'b0;
            align_fail <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            smp_cnt    <= smp_nx;
            err_cnt    <= err_nx;
            pass_map   <= pass_nx;
            retry_cnt  <= retry_nx;
            run        <= run_nx;
            best       <= best_nx;
            best_end   <= best_end_nx;
            psda       <= psda_nx;
            eye_start  <= eye_start_nx;
            eye_width  <= eye_width_nx;
            pll_reset  <= (state_nx == ST_PLL_RST);
            busy       <= !(state_nx == ST_IDLE || state_nx == ST_DONE || state_nx == ST_FAIL);
            aligned    <= (state_nx == ST_DONE);
            align_fail <= (state_nx == ST_FAIL);
        end
    end

endmodule
